// File: rtl/link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// link_tx_scheduler
//
// Transmit-side controller for the messenger link. Two byte requesters share
// one encrypt-and-serialize path:
//   ch0 : keyboard characters
//   ch1 : control / ack bytes
// A round-robin arbiter picks a requester while the line is idle. The granted
// byte is run through the team cipher and then shifted out as a framed
// character by an explicit frame FSM:
//   IDLE -> START -> DATA (8 bits, LSB first) -> [PARITY] -> STOP -> IDLE
// Every non-IDLE bit period lasts CLKS_PER_BIT clock cycles.
//
// Optional build macro:
//   LINK_TX_PARITY_EN : inserts a PARITY state between DATA and STOP that
//                       drives the even-parity bit (XOR of enc_byte). Frames
//                       grow from 10 to 11 bit periods. When undefined, no
//                       parity state or parity logic exists.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit, 1..255
//   KEY          : private XOR key applied after bit scrambling
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   req0_valid  in   ch0 has a byte
//   req0_data   in   ch0 plaintext byte [7:0]
//   req0_ready  out  ch0 byte accepted on this edge when valid & ready
//   req1_valid  in   ch1 has a byte
//   req1_data   in   ch1 plaintext byte [7:0]
//   req1_ready  out  ch1 byte accepted on this edge when valid & ready
//   serial_out  out  framed serial line, idles at 1
//   busy        out  a frame is in progress (state != IDLE)
//   grant_id    out  channel owning the current / most recent frame
//   frame_done  out  one-cycle pulse during the last cycle of the stop bit
//   enc_byte    out  encrypted byte of the current frame (monitor tap)
//
// Handshake: a byte transfers on a rising clock edge where reqN_valid and
// reqN_ready are both high. ready is raised only in IDLE and only for the
// channel the arbiter picked, so at most one ready is ever high. A requester
// that is not ready may change or drop valid/data freely; nothing is taken
// from it until it sees its own ready.
// -----------------------------------------------------------------------------
module link_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic [7:0]  KEY          = 8'd43
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done,
  output logic [7:0] enc_byte
);

  // Explicit encodings keep the state values stable whether or not the
  // parity state is compiled in.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef LINK_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);

  // Frame FSM state and its datapath registers.
  state_t     state_q,      state_d;
  logic [7:0] bit_timer_q,  bit_timer_d;
  logic [2:0] bit_idx_q,    bit_idx_d;
  logic [7:0] enc_q,        enc_d;
  logic       grant_q,      grant_d;
  logic       last_grant_q, last_grant_d;

  logic       idle;
  logic       bit_end;
  logic       pick1;
  logic       accept;

  // Team cipher: invert bits 0/2/4/6, swap positions 1 <- 3 <- 5 <- 1,
  // keep bit 7, then XOR with the key.
  function automatic logic [7:0] cipher(input logic [7:0] m);
    logic [7:0] t;
    t = {m[7], ~m[6], m[1], ~m[4], m[5], ~m[2], m[3], ~m[0]};
    return t ^ KEY;
  endfunction

  assign idle = (state_q == S_IDLE);

  // End of the current bit period. With one clock per bit every cycle ends a
  // bit, so the timer is never consulted and folds away.
  assign bit_end = (CLKS_PER_BIT == 1) ? 1'b1 : (bit_timer_q == TIMER_LAST);

  // Round-robin pick: a lone valid wins; on a tie the channel that did not
  // own the previous frame wins. last_grant resets to 1 so ch0 wins first.
  assign pick1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = idle & req0_valid & ~pick1;
  assign req1_ready = idle & pick1;

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign busy     = ~idle;
  assign grant_id = grant_q;
  assign enc_byte = enc_q;

  // Next-state, datapath and line-level logic.
  always_comb begin
    state_d      = state_q;
    bit_timer_d  = bit_timer_q;
    bit_idx_d    = bit_idx_q;
    enc_d        = enc_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    serial_out   = 1'b1;
    frame_done   = 1'b0;

    // Bit timer runs in every non-idle state and wraps at each bit boundary.
    if (!idle) begin
      bit_timer_d = bit_end ? 8'd0 : (bit_timer_q + 8'd1);
    end

    case (state_q)
      S_IDLE: begin
        bit_timer_d = 8'd0;
        bit_idx_d   = 3'd0;
        if (accept) begin
          enc_d        = cipher(pick1 ? req1_data : req0_data);
          grant_d      = pick1;
          last_grant_d = pick1;
          state_d      = S_START;
        end
      end

      S_START: begin
        serial_out = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        serial_out = enc_q[bit_idx_q];
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef LINK_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef LINK_TX_PARITY_EN
      S_PARITY: begin
        serial_out = ^enc_q;
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        serial_out = 1'b1;
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Reset drops any in-flight byte without a frame_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_timer_q  <= 8'd0;
      bit_idx_q    <= 3'd0;
      enc_q        <= 8'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_timer_q  <= bit_timer_d;
      bit_idx_q    <= bit_idx_d;
      enc_q        <= enc_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_link_tx_scheduler
//
// Two instances share clock and reset: dut_a runs one clock per bit, dut_b
// runs four clocks per bit. Expected line bits come from a reference model
// that builds the whole frame (start, cipher byte LSB first, optional parity,
// stop) as a list of bits in exp_q; arbitration is predicted from a
// round-robin "last winner" variable.
// -----------------------------------------------------------------------------
module tb_link_tx_scheduler;

  localparam logic [7:0] KEY_VAL = 8'd43;
`ifdef LINK_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- dut_a (1 clk/bit)
  logic       a_req0_valid, a_req1_valid;
  logic [7:0] a_req0_data,  a_req1_data;
  logic       a_req0_ready, a_req1_ready;
  logic       a_serial, a_busy, a_gid, a_done;
  logic [7:0] a_enc;

  link_tx_scheduler #(.CLKS_PER_BIT(1), .KEY(KEY_VAL)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (a_req0_valid),
    .req0_data  (a_req0_data),
    .req0_ready (a_req0_ready),
    .req1_valid (a_req1_valid),
    .req1_data  (a_req1_data),
    .req1_ready (a_req1_ready),
    .serial_out (a_serial),
    .busy       (a_busy),
    .grant_id   (a_gid),
    .frame_done (a_done),
    .enc_byte   (a_enc)
  );

  // ---------------------------------------------------------------- dut_b (4 clk/bit)
  logic       b_req0_valid, b_req1_valid;
  logic [7:0] b_req0_data,  b_req1_data;
  logic       b_req0_ready, b_req1_ready;
  logic       b_serial, b_busy, b_gid, b_done;
  logic [7:0] b_enc;

  link_tx_scheduler #(.CLKS_PER_BIT(4), .KEY(KEY_VAL)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (b_req0_valid),
    .req0_data  (b_req0_data),
    .req0_ready (b_req0_ready),
    .req1_valid (b_req1_valid),
    .req1_data  (b_req1_data),
    .req1_ready (b_req1_ready),
    .serial_out (b_serial),
    .busy       (b_busy),
    .grant_id   (b_gid),
    .frame_done (b_done),
    .enc_byte   (b_enc)
  );

  // ---------------------------------------------------------------- scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [0:0] exp_q[$];

  // Cipher from its rule table: output bit i takes plaintext bit src[i],
  // inverted when i is even, then XORed with the key.
  function automatic logic [7:0] model_cipher(input logic [7:0] m);
    int         src [8] = '{0, 3, 2, 5, 4, 1, 6, 7};
    logic [7:0] key = KEY_VAL;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = m[src[i]] ^ ((i % 2) == 0) ^ key[i];
    end
    return r;
  endfunction

  // Push one whole frame, each bit repeated cpb times.
  task automatic push_frame(input logic [7:0] enc, input int cpb);
    logic [0:0] bits [$];
    int         ones;
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bits.push_back(enc[i]);
      ones += int'(enc[i]);
    end
`ifdef LINK_TX_PARITY_EN
    bits.push_back(1'((ones % 2) == 1));
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < cpb; c++) exp_q.push_back(bits[i]);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_reset;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs;
    a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_data = 8'h00; a_req1_data = 8'h00;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = 8'h00; b_req1_data = 8'h00;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL reset a_serial got %b exp 1", a_serial); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset a_busy got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset a_done got %b exp 0", a_done); end
    checks++; if (a_gid !== 1'b0) begin errors++; $display("FAIL reset a_gid got %b exp 0", a_gid); end
    checks++; if (a_enc !== 8'h00) begin errors++; $display("FAIL reset a_enc got %h exp 00", a_enc); end
    checks++; if ({a_req0_ready, a_req1_ready} !== 2'b00) begin errors++; $display("FAIL reset a_ready got %b exp 00", {a_req0_ready, a_req1_ready}); end
    checks++; if ({b_serial, b_busy, b_done, b_gid} !== 4'b1000) begin errors++; $display("FAIL reset b_flags got %b exp 1000", {b_serial, b_busy, b_done, b_gid}); end
    checks++; if (b_enc !== 8'h00) begin errors++; $display("FAIL reset b_enc got %h exp 00", b_enc); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_ch0;
    logic [0:0] exp_bit;
    logic       exp_done;
    do_reset;
    a_req0_data  = 8'h41;
    a_req0_valid = 1'b1;
    @(negedge clock);
    checks++; if ({a_req0_ready, a_req1_ready} !== 2'b10) begin errors++; $display("FAIL single ready got %b exp 10", {a_req0_ready, a_req1_ready}); end
    @(posedge clock); #1;
    a_req0_valid = 1'b0;
    exp_q.delete();
    push_frame(model_cipher(8'h41), 1);
    for (int k = 0; k < FRAME_BITS; k++) begin
      @(negedge clock);
      exp_bit  = exp_q.pop_front();
      exp_done = (k == FRAME_BITS - 1);
      checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL single serial k=%0d got %b exp %b", k, a_serial, exp_bit); end
      checks++; if (a_done !== exp_done) begin errors++; $display("FAIL single done k=%0d got %b exp %b", k, a_done, exp_done); end
      if (k == 0) begin
        checks++; if (a_enc !== 8'h3F) begin errors++; $display("FAIL single enc got %h exp 3f", a_enc); end
        checks++; if (a_gid !== 1'b0) begin errors++; $display("FAIL single gid got %b exp 0", a_gid); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single busy got %b exp 1", a_busy); end
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++; if ({a_busy, a_serial, a_done} !== 3'b010) begin errors++; $display("FAIL single after got %b exp 010", {a_busy, a_serial, a_done}); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    logic       last;
    logic       exp_g;
    logic [7:0] exp_enc;
    logic [0:0] exp_bit;
    logic       exp_done;
    do_reset;
    last = 1'b1;
    a_req0_data = 8'h00; a_req1_data = 8'h41;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    for (int f = 0; f < 8; f++) begin
      exp_g = ~last;
      @(negedge clock);
      checks++; if ({a_busy, a_serial} !== 2'b01) begin errors++; $display("FAIL b2b gap f=%0d got %b exp 01", f, {a_busy, a_serial}); end
      checks++; if ({a_req1_ready, a_req0_ready} !== {exp_g, ~exp_g}) begin errors++; $display("FAIL b2b ready f=%0d got %b exp %b", f, {a_req1_ready, a_req0_ready}, {exp_g, ~exp_g}); end
      exp_enc = model_cipher(exp_g ? a_req1_data : a_req0_data);
      @(posedge clock); #1;
      last = exp_g;
      if (f >= 2) begin
        if (exp_g) a_req1_data = 8'($urandom_range(0, 255));
        else       a_req0_data = 8'($urandom_range(0, 255));
      end
      exp_q.delete();
      push_frame(exp_enc, 1);
      for (int k = 0; k < FRAME_BITS; k++) begin
        @(negedge clock);
        exp_bit  = exp_q.pop_front();
        exp_done = (k == FRAME_BITS - 1);
        checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL b2b serial f=%0d k=%0d got %b exp %b", f, k, a_serial, exp_bit); end
        checks++; if (a_done !== exp_done) begin errors++; $display("FAIL b2b done f=%0d k=%0d got %b exp %b", f, k, a_done, exp_done); end
        checks++; if ({a_req0_ready, a_req1_ready} !== 2'b00) begin errors++; $display("FAIL b2b busy_ready f=%0d k=%0d got %b exp 00", f, k, {a_req0_ready, a_req1_ready}); end
        if (k == 0) begin
          checks++; if (a_gid !== exp_g) begin errors++; $display("FAIL b2b gid f=%0d got %b exp %b", f, a_gid, exp_g); end
          checks++; if (a_enc !== exp_enc) begin errors++; $display("FAIL b2b enc f=%0d got %h exp %h", f, a_enc, exp_enc); end
          if (f < 4) begin
            checks++; if (a_enc !== ((f % 2 == 1) ? 8'h3F : 8'h7E)) begin errors++; $display("FAIL b2b enc_const f=%0d got %h", f, a_enc); end
          end
        end
        @(posedge clock); #1;
      end
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    logic       last;
    logic [1:0] pat;
    logic       exp_g;
    logic [7:0] exp_enc;
    logic [0:0] exp_bit;
    logic       exp_done;
    int         gap;
    do_reset;
    last = 1'b1;
    for (int n = 0; n < 16; n++) begin
      pat = 2'($urandom_range(1, 3));
      a_req0_data = 8'($urandom_range(0, 255));
      a_req1_data = 8'($urandom_range(0, 255));
      a_req0_valid = pat[0];
      a_req1_valid = pat[1];
      exp_g = (pat == 2'b11) ? ~last : pat[1];
      exp_enc = model_cipher(exp_g ? a_req1_data : a_req0_data);
      @(negedge clock);
      checks++; if ({a_req1_ready, a_req0_ready} !== {exp_g, ~exp_g}) begin errors++; $display("FAIL rand ready n=%0d got %b exp %b", n, {a_req1_ready, a_req0_ready}, {exp_g, ~exp_g}); end
      @(posedge clock); #1;
      a_req0_valid = 1'b0; a_req1_valid = 1'b0;
      last = exp_g;
      exp_q.delete();
      push_frame(exp_enc, 1);
      for (int k = 0; k < FRAME_BITS; k++) begin
        @(negedge clock);
        exp_bit  = exp_q.pop_front();
        exp_done = (k == FRAME_BITS - 1);
        checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL rand serial n=%0d k=%0d got %b exp %b", n, k, a_serial, exp_bit); end
        checks++; if (a_done !== exp_done) begin errors++; $display("FAIL rand done n=%0d k=%0d got %b exp %b", n, k, a_done, exp_done); end
        if (k == 0) begin
          checks++; if (a_gid !== exp_g) begin errors++; $display("FAIL rand gid n=%0d got %b exp %b", n, a_gid, exp_g); end
          checks++; if (a_enc !== exp_enc) begin errors++; $display("FAIL rand enc n=%0d got %h exp %h", n, a_enc, exp_enc); end
        end
        @(posedge clock); #1;
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        checks++; if ({a_busy, a_serial, a_done, a_req0_ready, a_req1_ready} !== 5'b01000) begin errors++; $display("FAIL rand idle n=%0d got %b exp 01000", n, {a_busy, a_serial, a_done, a_req0_ready, a_req1_ready}); end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_slow_bits;
    int         total;
    logic [0:0] exp_bit;
    logic       exp_done;
    do_reset;
    b_req1_data  = 8'h00;
    b_req1_valid = 1'b1;
    @(negedge clock);
    checks++; if ({b_req1_ready, b_req0_ready} !== 2'b10) begin errors++; $display("FAIL slow ready got %b exp 10", {b_req1_ready, b_req0_ready}); end
    @(posedge clock); #1;
    b_req1_valid = 1'b0;
    exp_q.delete();
    push_frame(model_cipher(8'h00), 4);
    total = FRAME_BITS * 4;
    for (int k = 0; k < total; k++) begin
      @(negedge clock);
      exp_bit  = exp_q.pop_front();
      exp_done = (k == total - 1);
      checks++; if (b_serial !== exp_bit) begin errors++; $display("FAIL slow serial k=%0d got %b exp %b", k, b_serial, exp_bit); end
      checks++; if (b_done !== exp_done) begin errors++; $display("FAIL slow done k=%0d got %b exp %b", k, b_done, exp_done); end
      checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL slow busy k=%0d got %b exp 1", k, b_busy); end
      if (k == 0) begin
        checks++; if (b_enc !== 8'h7E) begin errors++; $display("FAIL slow enc got %h exp 7e", b_enc); end
        checks++; if (b_gid !== 1'b1) begin errors++; $display("FAIL slow gid got %b exp 1", b_gid); end
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++; if ({b_busy, b_serial} !== 2'b01) begin errors++; $display("FAIL slow after got %b exp 01", {b_busy, b_serial}); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_frame;
    logic [0:0] exp_bit;
    logic       exp_done;
    do_reset;
    a_req0_data  = 8'($urandom_range(0, 255));
    a_req0_valid = 1'b1;
    @(posedge clock); #1;
    a_req0_valid = 1'b0;
    exp_q.delete();
    push_frame(model_cipher(a_req0_data), 1);
    // cycle 0 is the start bit, cycle 3 is the third data bit
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      exp_bit = exp_q.pop_front();
      checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL midrst serial k=%0d got %b exp %b", k, a_serial, exp_bit); end
      if (k == 3) reset = 1'b1;
      @(posedge clock); #1;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if ({a_serial, a_busy, a_done} !== 3'b100) begin errors++; $display("FAIL midrst idle c=%0d got %b exp 100", c, {a_serial, a_busy, a_done}); end
      checks++; if (a_enc !== 8'h00) begin errors++; $display("FAIL midrst enc c=%0d got %h exp 00", c, a_enc); end
      @(posedge clock); #1;
    end
    a_req1_data  = 8'h01;
    a_req1_valid = 1'b1;
    @(posedge clock); #1;
    a_req1_valid = 1'b0;
    exp_q.delete();
    push_frame(model_cipher(8'h01), 1);
    for (int k = 0; k < FRAME_BITS; k++) begin
      @(negedge clock);
      exp_bit  = exp_q.pop_front();
      exp_done = (k == FRAME_BITS - 1);
      checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL midrst refr serial k=%0d got %b exp %b", k, a_serial, exp_bit); end
      checks++; if (a_done !== exp_done) begin errors++; $display("FAIL midrst refr done k=%0d got %b exp %b", k, a_done, exp_done); end
      if (k == 0) begin
        checks++; if ({a_gid, a_enc} !== {1'b1, 8'h7F}) begin errors++; $display("FAIL midrst refr gid_enc got %b/%h exp 1/7f", a_gid, a_enc); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_ignore_midframe;
    logic [0:0] exp_bit;
    logic       exp_done;
    do_reset;
    a_req0_data  = 8'($urandom_range(0, 255));
    a_req0_valid = 1'b1;
    @(posedge clock); #1;
    a_req0_valid = 1'b0;
    exp_q.delete();
    push_frame(model_cipher(a_req0_data), 1);
    for (int k = 0; k < FRAME_BITS; k++) begin
      @(negedge clock);
      exp_bit  = exp_q.pop_front();
      exp_done = (k == FRAME_BITS - 1);
      checks++; if (a_serial !== exp_bit) begin errors++; $display("FAIL ignore serial k=%0d got %b exp %b", k, a_serial, exp_bit); end
      checks++; if (a_done !== exp_done) begin errors++; $display("FAIL ignore done k=%0d got %b exp %b", k, a_done, exp_done); end
      checks++; if (a_req1_ready !== 1'b0) begin errors++; $display("FAIL ignore ready1 k=%0d got %b exp 0", k, a_req1_ready); end
      if (k == 2) begin
        a_req1_data  = 8'($urandom_range(0, 255));
        a_req1_valid = 1'b1;
      end
      if (k == FRAME_BITS - 3) a_req1_valid = 1'b0;
      @(posedge clock); #1;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if ({a_busy, a_serial, a_done, a_req1_ready} !== 4'b0100) begin errors++; $display("FAIL ignore after c=%0d got %b exp 0100", c, {a_busy, a_serial, a_done, a_req1_ready}); end
      @(posedge clock); #1;
    end
  endtask

`ifdef LINK_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] plain [2] = '{8'h41, 8'h01};
    logic       par   [2] = '{1'b0, 1'b1};
    for (int p = 0; p < 2; p++) begin
      do_reset;
      a_req0_data  = plain[p];
      a_req0_valid = 1'b1;
      @(posedge clock); #1;
      a_req0_valid = 1'b0;
      for (int k = 0; k < FRAME_BITS; k++) begin
        @(negedge clock);
        if (k == 9) begin
          checks++; if (a_serial !== par[p]) begin errors++; $display("FAIL parity p=%0d got %b exp %b", p, a_serial, par[p]); end
        end
        if (k == 10) begin
          checks++; if ({a_serial, a_done} !== 2'b11) begin errors++; $display("FAIL parity stop p=%0d got %b exp 11", p, {a_serial, a_done}); end
        end
        @(posedge clock); #1;
      end
    end
  endtask
`endif

  // ---------------------------------------------------------------- sequence
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_ch0();
    test_back_to_back();
    test_random();
    test_slow_bits();
    test_reset_mid_frame();
    test_ignore_midframe();
`ifdef LINK_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Transmit-side controller for the messenger link.
- Arbitrates between two byte requesters (ch0 = keyboard characters, ch1 = control/ack bytes) that share one encrypt-and-serialize path.
- Encrypts the granted byte with the team cipher and sequences it onto the single serial line as a framed character.
- Replaces the free-running divide-by-8 load counter with an explicit, handshaked frame FSM.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit; legal values are 1 to 255.
- KEY, 8'd43, private XOR key applied after bit scrambling.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  ch0 has a byte
- req0_data  input  8  ch0 plaintext byte
- req0_ready  output  1  ch0 byte accepted this cycle when valid&ready
- req1_valid  input  1  ch1 has a byte
- req1_data  input  8  ch1 plaintext byte
- req1_ready  output  1  ch1 accept
- serial_out  output  1  framed serial line; idle level 1
- busy  output  1  frame in progress (state != IDLE)
- grant_id  output  1  channel owning the current/last frame
- frame_done  output  1  one-cycle pulse at end of stop bit
- enc_byte  output  8  encrypted byte of the current frame (monitor tap)

Behaviour:
- Reset values (synchronous, active-high): serial_out=1, busy=0, frame_done=0, grant_id=0, enc_byte=0. Internally, state=IDLE and last_grant=1, so ch0 wins the first tie.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Every non-IDLE state lasts CLKS_PER_BIT cycles, timed by an 8-bit bit-timer. DATA lasts 8 bit periods, tracked by a 3-bit bit index.
- Arbitration happens in IDLE only and is combinational from the valids:
  - One valid: that channel is granted.
  - Both valid: the channel != last_grant is granted (round-robin).
  - reqN_ready is high only in IDLE, only for the granted channel; it is never high for both channels at once.
- Accept: on the clock edge where valid&ready, the FSM latches enc_byte, sets grant_id and last_grant, and moves to START. Ungranted requests hold off; no data is lost.
- Cipher, applied to plaintext m to give enc:
  - Bits 0, 2, 4, 6 are inverted.
  - t1=m3, t3=m5, t5=m1.
  - t7=m7.
  - enc = t ^ KEY.
  - Examples: 0x41 -> 0x3F, 0x00 -> 0x7E.
- Frame on serial_out:
  - START drives 0.
  - DATA drives enc_byte LSB first.
  - STOP drives 1.
  - IDLE drives 1.
- Latency: the start bit appears on serial_out in the cycle after the accept edge. Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- frame_done is high during the last cycle of STOP. The next state is IDLE.
- Minimum gap between frames is one IDLE cycle, so back-to-back frames are separated by at least one extra 1 on the line.
- Requests arriving while busy are not accepted. Valids may change freely while not ready.
- Reset mid-frame: the next cycle is IDLE with serial_out=1. The in-flight byte is dropped and frame_done is not pulsed.
- If CLKS_PER_BIT=1 the bit-timer is unused, and each bit is exactly one cycle.

Optional Feature:
- Macro: LINK_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit of enc_byte (XOR of its 8 bits) for CLKS_PER_BIT cycles, and frame length becomes 11 bit periods.
- Undefined: no PARITY state, 10-bit frames, and no parity logic is synthesized.

Test Plan:
- Reset, then req0_valid=1 with req0_data=0x41 (CLKS_PER_BIT=1) -> req0_ready=1 for one cycle, enc_byte=0x3F, grant_id=0. Next cycles serial_out=0,1,1,1,1,1,1,0,0,1, frame_done on the final 1, busy low after it.
- req0 and req1 both valid with 0x00 and 0x41 continuously, from reset -> grants alternate ch0, ch1, ch0, ch1. enc_byte alternates 0x7E, 0x3F. At least one idle 1 separates frames.
- CLKS_PER_BIT=4, single ch1 byte 0x00 -> each bit held exactly 4 cycles, 40-cycle frame, data bits 0,1,1,1,1,1,1,0 (0x7E LSB first).
- Assert reset in the 3rd data bit of a frame -> the next cycle has serial_out=1, busy=0, no frame_done. A subsequent request frames correctly from start.
- LINK_TX_PARITY_EN defined, byte 0x41 -> parity bit 0 (0x3F has six 1s) between the last data bit and stop. Byte 0x01 (enc 0x7F) -> parity bit 1.
- req1_valid asserted mid-frame and dropped before IDLE -> req1_ready never asserted, no extra frame emitted.
